mix_columns_seq: RTL
====================

// Module: mix_columns_seq
// PURPOSE
//  Sequential, handshaked AES MixColumns/InvMixColumns engine. Processes a full
//  N x N byte state COLS_PER_CYCLE columns per clock, so the GF(2^8) multiplier
//  count can be traded against latency. Sits between ShiftRows and AddRoundKey
//  in the iterative round datapath; one block serves both encrypt and decrypt.
// PARAMETERS
//  N               4  state dimension; only 4 is legal (elaboration error otherwise)
//  COLS_PER_CYCLE  1  columns processed per BUSY cycle; legal values 1, 2, 4
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        state_in/inverse valid
//  in_ready   out  1        block can accept a state
//  inverse    in   1        0 = MixColumns, 1 = InvMixColumns; sampled on accept
//  state_in   in   [7:0][N][N]  input state; state_in[c][r] = column c, row r
//  out_valid  out  1        state_out holds a completed result
//  out_ready  in   1        downstream accepts state_out
//  state_out  out  [7:0][N][N]  result state, same indexing as state_in
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): FSM->IDLE, col counter=0, out_valid=0,
//    in_ready=1 after reset, state_out all bytes 8'h00, input regs cleared.
//    Reset mid-operation aborts: in-flight state and pending result are dropped.
//  - FSM states: IDLE, BUSY, DONE.
//    IDLE: in_ready=1. On in_valid=1 latch state_in and inverse, col=0 -> BUSY.
//    BUSY: in_ready=0. Each cycle compute columns col..col+COLS_PER_CYCLE-1 from
//      latched input, write them into state_out regs, col += COLS_PER_CYCLE.
//      After the group ending at column N-1: col=0 -> DONE.
//    DONE: out_valid=1, in_ready=0. On out_ready=1 -> IDLE, out_valid=0.
//      With out_ready=0, state_out and out_valid hold indefinitely.
//  - Latency: out_valid rises N/COLS_PER_CYCLE cycles after the accept edge
//    (4 for CPC=1, 2 for CPC=2, 1 for CPC=4). Throughput: one state per
//    N/COLS_PER_CYCLE + 2 cycles with out_ready tied high.
//  - in_valid/state_in/inverse changes while not IDLE are ignored; no drop, no
//    corruption. in_ready is a function of state only (no in_valid->in_ready path).
//  - state_out is only defined when out_valid=1; partially written columns are
//    visible in BUSY and must not be consumed.
//  - Arithmetic, per column a0..a3 -> b0..b3 (circulant, row r rotates by r):
//    forward  b_r = 02*a_r ^ 03*a_(r+1) ^ 01*a_(r+2) ^ 01*a_(r+3)
//    inverse  b_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3)
//    indices mod 4; multiply in GF(2^8) mod x^8+x^4+x^3+x+1 (xtime reduce 8'h1b).
//  - All outputs registered; no combinational path input->output.
// TESTING
//  1 Fwd, CPC=1: column 0 = db 13 53 45 -> state_out[0] = 8e 4d a1 bc;
//    column f2 0a 22 5c -> 9f dc 58 9d; out_valid exactly 4 cycles after accept.
//  2 Inverse: column 8e 4d a1 bc, inverse=1 -> db 13 53 45; fixed points
//    01 01 01 01 and c6 c6 c6 c6 map to themselves in both modes.
//  3 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and
//    state_out stable, in_ready=0; new in_valid ignored until DONE->IDLE.
//  4 Reset mid-BUSY (after 2 cycles): next cycle out_valid=0, in_ready=1,
//    state_out=0; next accepted state completes with correct result.
//  5 Sweep CPC in {1,2,4} with 1000 random states/modes vs software model;
//    fwd-then-inverse round-trip equals original; latency = 4/CPC.

Source files
------------

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine with valid/ready handshake.
// Computes COLS_PER_CYCLE columns of the 4x4 byte state on each BUSY cycle.
module mix_columns_seq #(
    parameter int unsigned N              = 4,
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         inverse,
    input  logic [N-1:0][N-1:0][7:0]     state_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0][N-1:0][7:0]     state_out
);

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned COL_W    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LAST_COL = N - COLS_PER_CYCLE;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Only the AES geometry and divisors of the column count are supported.
    generate
        if (N != 4) begin : g_bad_n
            $error("mix_columns_seq: N must be 4");
        end
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef logic [N-1:0][BYTE_W-1:0] col_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One circulant column transform; constants built from x2/x4/x8 partials.
    function automatic col_t mix_col(input col_t a, input logic inv);
        col_t       x2;
        col_t       x4;
        col_t       x8;
        col_t       b;
        logic [1:0] i0;
        logic [1:0] i1;
        logic [1:0] i2;
        logic [1:0] i3;
        x2 = '0;
        x4 = '0;
        x8 = '0;
        b  = '0;
        for (int k = 0; k < 4; k++) begin
            x2[2'(k)] = xtime(a[2'(k)]);
            x4[2'(k)] = xtime(x2[2'(k)]);
            x8[2'(k)] = xtime(x4[2'(k)]);
        end
        for (int r = 0; r < 4; r++) begin
            i0 = 2'(r);
            i1 = 2'(r + 1);
            i2 = 2'(r + 2);
            i3 = 2'(r + 3);
            if (inv) begin
                b[i0] = (x8[i0] ^ x4[i0] ^ x2[i0])
                      ^ (x8[i1] ^ x2[i1] ^ a[i1])
                      ^ (x8[i2] ^ x4[i2] ^ a[i2])
                      ^ (x8[i3] ^ a[i3]);
            end else begin
                b[i0] = x2[i0] ^ (x2[i1] ^ a[i1]) ^ a[i2] ^ a[i3];
            end
        end
        return b;
    endfunction

    logic [1:0]                              state_q;
    logic [1:0]                              state_d;
    logic [COL_W-1:0]                        col_q;
    logic [COL_W-1:0]                        col_d;
    logic [N-1:0][N-1:0][BYTE_W-1:0]         in_q;
    logic [N-1:0][N-1:0][BYTE_W-1:0]         out_q;
    logic                                    inv_q;
    logic                                    in_ready_q;
    logic                                    out_valid_q;
    logic                                    accept_c;
    logic                                    last_grp_c;
    logic [COLS_PER_CYCLE-1:0][COL_W-1:0]    grp_idx_c;
    logic [COLS_PER_CYCLE-1:0][N-1:0][BYTE_W-1:0] grp_res_c;

    // Next-state and column-counter logic.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        accept_c   = 1'b0;
        last_grp_c = (col_q == COL_W'(LAST_COL));
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    col_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (last_grp_c) begin
                    col_d   = '0;
                    state_d = DONE;
                end else begin
                    col_d = col_q + COL_W'(COLS_PER_CYCLE);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                col_d   = '0;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    // Capture the operand so upstream may change it freely after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= '0;
            inv_q <= 1'b0;
        end else if (accept_c) begin
            in_q  <= state_in;
            inv_q <= inverse;
        end
    end

    // Columns handled in the current BUSY cycle.
    always_comb begin
        grp_idx_c = '0;
        grp_res_c = '0;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            grp_idx_c[g] = col_q + COL_W'(g);
            grp_res_c[g] = mix_col(in_q[grp_idx_c[g]], inv_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (state_q == BUSY) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                out_q[grp_idx_c[g]] <= grp_res_c[g];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign state_out = out_q;

endmodule
